// File: rtl/n101_hclkgen_ctrl_pkg.sv
// Shared definitions for the HCLK generator control block: register map,
// PLLCFG field layout, reset values and sequencer state encodings.
package n101_hclkgen_ctrl_pkg;

  localparam int unsigned ADDR_W = 12;

  // Register byte offsets
  localparam logic [ADDR_W-1:0] OFF_HFXOSCCFG = 12'h004;
  localparam logic [ADDR_W-1:0] OFF_PLLCFG    = 12'h008;
  localparam logic [ADDR_W-1:0] OFF_PLLCTL    = 12'h010;
  localparam logic [ADDR_W-1:0] OFF_PLLSTS    = 12'h014;
  localparam logic [ADDR_W-1:0] OFF_IRQEN     = 12'h018;
  localparam logic [ADDR_W-1:0] OFF_PLLOUTDIV = 12'h020;

  // PLLCFG field layout
  localparam int unsigned CFG_N_W        = 5;
  localparam int unsigned CFG_M_W        = 8;
  localparam int unsigned CFG_OD_W       = 2;
  localparam int unsigned CFG_N_LSB      = 0;
  localparam int unsigned CFG_M_LSB      = 5;
  localparam int unsigned CFG_OD_LSB     = 13;
  localparam int unsigned CFG_BYPASS_BIT = 18;
  localparam int unsigned CFG_ASLEEP_BIT = 29;
  localparam int unsigned CFG_LOCK_BIT   = 31;

  // Other register bit positions
  localparam int unsigned HFXOSC_EN_BIT  = 30;
  localparam int unsigned STS_BUSY_BIT   = 4;
  localparam int unsigned STS_ERR_BIT    = 5;
  localparam int unsigned STS_DONE_BIT   = 6;
  localparam int unsigned DIV_BY1_BIT    = 8;
  localparam int unsigned IRQEN_DONE_BIT = 0;
  localparam int unsigned IRQEN_ERR_BIT  = 1;

  typedef struct packed {
    logic                asleep;
    logic                bypass;
    logic [CFG_OD_W-1:0] od;
    logic [CFG_M_W-1:0]  m;
    logic [CFG_N_W-1:0]  n;
  } pll_cfg_t;

  localparam pll_cfg_t PLL_CFG_RST = '{asleep: 1'b0, bypass: 1'b1, od: 2'd2, m: 8'h32, n: 5'd2};

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_BYPASS   = 3'd1,
    SEQ_RESET    = 3'd2,
    SEQ_LOCKWAIT = 3'd3,
    SEQ_SWITCH   = 3'd4,
    SEQ_ERR      = 3'd5
  } seq_state_e;

  // Place a PLL configuration into its PLLCFG register image
  function automatic logic [31:0] cfg_pack(input pll_cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CFG_N_LSB +: CFG_N_W]   = c.n;
    w[CFG_M_LSB +: CFG_M_W]   = c.m;
    w[CFG_OD_LSB +: CFG_OD_W] = c.od;
    w[CFG_BYPASS_BIT]         = c.bypass;
    w[CFG_ASLEEP_BIT]         = c.asleep;
    return w;
  endfunction

endpackage

// File: rtl/n101_hclkgen_pllseq.sv
// PLL reconfiguration sequencer: lock synchroniser, state machine and a
// saturating cycle counter shared by the reset pulse and the lock timeout.
module n101_hclkgen_pllseq
  import n101_hclkgen_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYC = 16,
  parameter int unsigned LOCK_TO = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       lock_i,
  output logic [2:0] state_o,
  output logic       lock_sync_o,
  output logic       load_cfg_c_o,
  output logic       pll_reset_o,
  output logic       force_bypass_o,
  output logic       done_set_o,
  output logic       err_set_o
);

  localparam int unsigned CNT_W = $clog2((RST_CYC > LOCK_TO) ? RST_CYC : LOCK_TO);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             lock_meta_q;
  logic             lock_sync_q;
  logic             pll_reset_q;
  logic             force_bypass_q;
  logic             done_set_q;
  logic             err_set_q;

  // Saturating increment so the counter can never wrap
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Sequencer FSM with registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEQ_IDLE;
      cnt_q          <= '0;
      pll_reset_q    <= 1'b0;
      force_bypass_q <= 1'b0;
      done_set_q     <= 1'b0;
      err_set_q      <= 1'b0;
    end else begin
      done_set_q <= 1'b0;
      err_set_q  <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start_i) begin
            state_q        <= SEQ_BYPASS;
            force_bypass_q <= 1'b1;
          end
        end
        SEQ_BYPASS: begin
          state_q     <= SEQ_RESET;
          cnt_q       <= '0;
          pll_reset_q <= 1'b1;
        end
        SEQ_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q     <= SEQ_LOCKWAIT;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        SEQ_LOCKWAIT: begin
          // Lock takes priority over a timeout in the same cycle
          if (lock_sync_q) begin
            state_q        <= SEQ_SWITCH;
            force_bypass_q <= 1'b0;
            done_set_q     <= 1'b1;
          end else if (cnt_q == LOCK_LAST) begin
            state_q   <= SEQ_ERR;
            err_set_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        SEQ_SWITCH: begin
          state_q <= SEQ_IDLE;
        end
        SEQ_ERR: begin
          state_q        <= SEQ_IDLE;
          force_bypass_q <= 1'b0;
        end
        default: begin
          state_q        <= SEQ_IDLE;
          pll_reset_q    <= 1'b0;
          force_bypass_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_o        = state_q;
  assign lock_sync_o    = lock_sync_q;
  assign load_cfg_c_o   = (state_q == SEQ_IDLE) && start_i;
  assign pll_reset_o    = pll_reset_q;
  assign force_bypass_o = force_bypass_q;
  assign done_set_o     = done_set_q;
  assign err_set_o      = err_set_q;

endmodule

// File: rtl/n101_hclkgen_ctrl.sv
// HCLK generator control block on the peripheral ICB bus: oscillator enable,
// PLL shadow/live configuration, output dividers and the PLL sequencer.
// Optional interrupt register enabled by defining N101_HCLKGEN_IRQ_EN.
module n101_hclkgen_ctrl
  import n101_hclkgen_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIV = 2,
  parameter int unsigned DIV_W   = 6,
  parameter int unsigned RST_CYC = 16,
  parameter int unsigned LOCK_TO = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_icb_cmd_valid,
  output logic                     i_icb_cmd_ready,
  input  logic [ADDR_W-1:0]        i_icb_cmd_addr,
  input  logic                     i_icb_cmd_read,
  input  logic [31:0]              i_icb_cmd_wdata,
  output logic                     i_icb_rsp_valid,
  input  logic                     i_icb_rsp_ready,
  output logic [31:0]              i_icb_rsp_rdata,
  input  logic                     pll_lock,
  output logic                     hfxoscen,
  output logic                     pllbypass,
  output logic                     pll_RESET,
  output logic                     pll_ASLEEP,
  output logic [CFG_OD_W-1:0]      pll_OD,
  output logic [CFG_M_W-1:0]       pll_M,
  output logic [CFG_N_W-1:0]       pll_N,
  output logic [NUM_DIV-1:0]       plloutdivby1,
  output logic [NUM_DIV*DIV_W-1:0] plloutdiv,
  output logic                     irq
);

  logic        wr_en;
  logic        hit_hfx, hit_cfg, hit_ctl, hit_sts, hit_irqen;
  logic        busy;
  logic [2:0]  seq_state;
  logic        lock_sync, load_cfg_c, seq_force_bypass, done_set, err_set;
  logic        hfx_q, pllbypass_q, done_q, err_q;
  pll_cfg_t    cfg_q, live_q;
  logic [31:0] irqen_rdata;
  logic [31:0] div_rdata [NUM_DIV];
  logic [NUM_DIV-1:0] div_hit;
  logic        unused_sink;

  // Pass-through handshake and address decode
  assign i_icb_cmd_ready = i_icb_rsp_ready;
  assign i_icb_rsp_valid = i_icb_cmd_valid;
  assign wr_en     = i_icb_cmd_valid && i_icb_rsp_ready && !i_icb_cmd_read;
  assign hit_hfx   = (i_icb_cmd_addr == OFF_HFXOSCCFG);
  assign hit_cfg   = (i_icb_cmd_addr == OFF_PLLCFG);
  assign hit_ctl   = (i_icb_cmd_addr == OFF_PLLCTL);
  assign hit_sts   = (i_icb_cmd_addr == OFF_PLLSTS);
  assign hit_irqen = (i_icb_cmd_addr == OFF_IRQEN);
  assign busy      = (seq_state != SEQ_IDLE);

  n101_hclkgen_pllseq #(.RST_CYC(RST_CYC), .LOCK_TO(LOCK_TO)) u_pllseq (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (wr_en && hit_ctl && i_icb_cmd_wdata[0]),
    .lock_i         (pll_lock),
    .state_o        (seq_state),
    .lock_sync_o    (lock_sync),
    .load_cfg_c_o   (load_cfg_c),
    .pll_reset_o    (pll_RESET),
    .force_bypass_o (seq_force_bypass),
    .done_set_o     (done_set),
    .err_set_o      (err_set)
  );

  // Oscillator enable, PLL shadow config (frozen while busy) and live config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hfx_q  <= 1'b1;
      cfg_q  <= PLL_CFG_RST;
      live_q <= PLL_CFG_RST;
    end else begin
      if (wr_en && hit_hfx) hfx_q <= i_icb_cmd_wdata[HFXOSC_EN_BIT];
      if (wr_en && hit_cfg && !busy) begin
        cfg_q.n      <= i_icb_cmd_wdata[CFG_N_LSB +: CFG_N_W];
        cfg_q.m      <= i_icb_cmd_wdata[CFG_M_LSB +: CFG_M_W];
        cfg_q.od     <= i_icb_cmd_wdata[CFG_OD_LSB +: CFG_OD_W];
        cfg_q.bypass <= i_icb_cmd_wdata[CFG_BYPASS_BIT];
        cfg_q.asleep <= i_icb_cmd_wdata[CFG_ASLEEP_BIT];
      end
      if (load_cfg_c) live_q <= cfg_q;
    end
  end

  // Bypass is forced high for the whole sequence and released only on success
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pllbypass_q <= 1'b1;
    end else if (load_cfg_c || seq_force_bypass) begin
      pllbypass_q <= 1'b1;
    end else if (done_set) begin
      pllbypass_q <= cfg_q.bypass;
    end
  end

  // Sticky status flags; the sequencer set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_set || (done_q && !(wr_en && hit_sts && i_icb_cmd_wdata[STS_DONE_BIT]));
      err_q  <= err_set  || (err_q  && !(wr_en && hit_sts && i_icb_cmd_wdata[STS_ERR_BIT]));
    end
  end

  // Per-channel output dividers
  for (genvar g = 0; g < NUM_DIV; g++) begin : g_div
    logic [DIV_W-1:0] div_q;
    logic             by1_q;

    assign div_hit[g] = (i_icb_cmd_addr == OFF_PLLOUTDIV + ADDR_W'(4 * g));

    // Channel ratio and divide-by-1 select, applied on write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q <= '0;
        by1_q <= 1'b1;
      end else if (wr_en && div_hit[g]) begin
        div_q <= i_icb_cmd_wdata[DIV_W-1:0];
        by1_q <= i_icb_cmd_wdata[DIV_BY1_BIT];
      end
    end

    assign plloutdiv[g*DIV_W +: DIV_W] = div_q;
    assign plloutdivby1[g]             = by1_q;
    assign div_rdata[g]                = (32'(by1_q) << DIV_BY1_BIT) | 32'(div_q);
  end

`ifdef N101_HCLKGEN_IRQ_EN
  logic done_ie_q, err_ie_q, irq_q;

  // Interrupt enables and registered interrupt output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_ie_q <= 1'b0;
      err_ie_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en && hit_irqen) begin
        done_ie_q <= i_icb_cmd_wdata[IRQEN_DONE_BIT];
        err_ie_q  <= i_icb_cmd_wdata[IRQEN_ERR_BIT];
      end
      irq_q <= (done_q && done_ie_q) || (err_q && err_ie_q);
    end
  end

  assign irq         = irq_q;
  assign irqen_rdata = (32'(err_ie_q) << IRQEN_ERR_BIT) | (32'(done_ie_q) << IRQEN_DONE_BIT);
`else
  assign irq         = 1'b0;
  assign irqen_rdata = '0;
`endif

  // Combinational read mux; unmapped addresses return zero
  always_comb begin
    i_icb_rsp_rdata = '0;
    if (hit_hfx) i_icb_rsp_rdata[HFXOSC_EN_BIT] = hfx_q;
    if (hit_cfg) begin
      i_icb_rsp_rdata               = cfg_pack(cfg_q);
      i_icb_rsp_rdata[CFG_LOCK_BIT] = lock_sync;
    end
    if (hit_sts) begin
      i_icb_rsp_rdata[2:0]          = seq_state;
      i_icb_rsp_rdata[STS_BUSY_BIT] = busy;
      i_icb_rsp_rdata[STS_ERR_BIT]  = err_q;
      i_icb_rsp_rdata[STS_DONE_BIT] = done_q;
    end
    if (hit_irqen) i_icb_rsp_rdata = irqen_rdata;
    for (int i = 0; i < NUM_DIV; i++) begin
      if (div_hit[i]) i_icb_rsp_rdata = div_rdata[i];
    end
  end

  assign hfxoscen    = hfx_q;
  assign pllbypass   = pllbypass_q;
  assign pll_N       = live_q.n;
  assign pll_M       = live_q.m;
  assign pll_OD      = live_q.od;
  assign pll_ASLEEP  = live_q.asleep;
  assign unused_sink = ^{i_icb_cmd_wdata, live_q.bypass};

endmodule

// File: tb/tb_n101_hclkgen_ctrl.sv
// Self-checking bench for n101_hclkgen_ctrl: reads are scored through an
// expected-response queue drained by a bus monitor; pin levels checked directly.
module tb_n101_hclkgen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        pll_lock = 1'b0;
  logic        hfxoscen, pllbypass, pll_RESET, pll_ASLEEP, irq;
  logic [1:0]  pll_OD;
  logic [7:0]  pll_M;
  logic [4:0]  pll_N;
  logic [1:0]  plloutdivby1;
  logic [11:0] plloutdiv;

  int tests_run = 0;
  int failures  = 0;
  logic [31:0] exp_data_q [$];
  string       exp_name_q [$];

  always #5 clk = ~clk;

  n101_hclkgen_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (cmd_valid),
    .i_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .i_icb_rsp_rdata (rsp_rdata),
    .pll_lock        (pll_lock),
    .hfxoscen        (hfxoscen),
    .pllbypass       (pllbypass),
    .pll_RESET       (pll_RESET),
    .pll_ASLEEP      (pll_ASLEEP),
    .pll_OD          (pll_OD),
    .pll_M           (pll_M),
    .pll_N           (pll_N),
    .plloutdivby1    (plloutdivby1),
    .plloutdiv       (plloutdiv),
    .irq             (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: score every read response against the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready && cmd_read) begin
      if (exp_data_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("FAIL unexpected_rsp: got 0x%08h with no expectation queued", rsp_rdata);
      end else begin
        string       nm;
        logic [31:0] e;
        nm = exp_name_q.pop_front();
        e  = exp_data_q.pop_front();
        chk(nm, rsp_rdata, e);
      end
    end
  end

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = addr;
    exp_data_q.push_back(exp);
    exp_name_q.push_back(nm);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_read = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = addr; cmd_wdata = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_reset_level(input logic lvl, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (pll_RESET === lvl) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++; failures++;
      $display("FAIL %s: timeout, pll_RESET never reached %0b", nm, lvl);
    end
  endtask

  // Count cycles pll_RESET stays high; returns one cycle after it falls
  task automatic measure_pulse(input string nm, output int n);
    bit low = 1'b0;
    n = 0;
    wait_reset_level(1'b1, nm);
    if (pll_RESET === 1'b1) n = 1;
    for (int i = 0; i < 200 && !low; i++) begin
      @(posedge clk); #1;
      if (pll_RESET === 1'b1) n++;
      else low = 1'b1;
    end
  endtask

  task automatic wait_bypass_low(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (pllbypass === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++; failures++;
      $display("FAIL %s: timeout, pllbypass never fell", nm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23 rst_n = 1'b1;

    // 1. Reset state
    chk("rst_pllbypass", 32'(pllbypass), 32'h1);
    chk("rst_pll_RESET", 32'(pll_RESET), 32'h0);
    chk("rst_pll_M", 32'(pll_M), 32'h32);
    rd(12'h004, 32'h4000_0000, "rst_hfxosccfg");
    rd(12'h008, 32'h0004_4642, "rst_pllcfg");
    rd(12'h020, 32'h0000_0100, "rst_div0");
    rd(12'h024, 32'h0000_0100, "rst_div1");
    rd(12'h014, 32'h0000_0000, "rst_pllsts");

    // 2. Successful reconfiguration
`ifdef N101_HCLKGEN_IRQ_EN
    wr(12'h018, 32'h1);
`endif
    wr(12'h008, 32'h0000_0A44);
    wr(12'h010, 32'h1);
    chk("bypass_state_M", 32'(pll_M), 32'h52);
    chk("bypass_state_N", 32'(pll_N), 32'h4);
    chk("bypass_state_OD", 32'(pll_OD), 32'h0);
    chk("bypass_state_pllbypass", 32'(pllbypass), 32'h1);
    measure_pulse("seq_ok_pulse", n);
    chk("seq_ok_reset_len", 32'(n), 32'd16);
    rd(12'h014, 32'h0000_0013, "lockwait_sts");
    repeat (47) @(posedge clk);
    #1 pll_lock = 1'b1;
    wait_bypass_low("seq_ok_switch");
    rd(12'h014, 32'h0000_0040, "done_sts");
    rd(12'h008, 32'h8000_0A44, "pllcfg_locked");
`ifdef N101_HCLKGEN_IRQ_EN
    chk("irq_done", 32'(irq), 32'h1);
`else
    chk("irq_tied_low", 32'(irq), 32'h0);
`endif
    wr(12'h014, 32'h40);
    rd(12'h014, 32'h0000_0000, "done_cleared");
    @(posedge clk); #1;
    chk("irq_after_clear", 32'(irq), 32'h0);

    // 3. Lock timeout
    pll_lock = 1'b0;
    repeat (5) @(posedge clk);
    wr(12'h010, 32'h1);
    measure_pulse("timeout_pulse", n);
    chk("timeout_reset_len", 32'(n), 32'd16);
    repeat (4093) @(posedge clk);
    rd(12'h014, 32'h0000_0013, "lockwait_last_cycles");
    rd(12'h014, 32'h0000_0015, "err_state");
    rd(12'h014, 32'h0000_0020, "timeout_err_set");
    chk("err_pllbypass", 32'(pllbypass), 32'h1);
    wr(12'h014, 32'h20);
    rd(12'h014, 32'h0000_0000, "timeout_err_cleared");

    // 4. Writes during LOCKWAIT are dropped, no restart
    wr(12'h010, 32'h1);
    measure_pulse("busy_pulse", n);
    chk("busy_reset_len", 32'(n), 32'd16);
    wr(12'h008, 32'h0);
    wr(12'h010, 32'h1);
    rd(12'h008, 32'h0000_0A44, "busy_cfg_dropped");
    chk("busy_live_M", 32'(pll_M), 32'h52);
    chk("busy_live_N", 32'(pll_N), 32'h4);
    rd(12'h014, 32'h0000_0013, "busy_no_restart");
    #1 pll_lock = 1'b1;
    wait_bypass_low("busy_switch");
    rd(12'h014, 32'h0000_0040, "busy_done");
    wr(12'h014, 32'h40);

    // 5. Output dividers and unmapped accesses
    wr(12'h024, 32'h0000_003F);
    chk("div1_ratio", 32'(plloutdiv[11:6]), 32'h3F);
    chk("div1_by1", 32'(plloutdivby1[1]), 32'h0);
    chk("div0_ratio", 32'(plloutdiv[5:0]), 32'h0);
    chk("div0_by1", 32'(plloutdivby1[0]), 32'h1);
    rd(12'h024, 32'h0000_003F, "div1_read");
    rd(12'h020, 32'h0000_0100, "div0_read");
    wr(12'h100, 32'hFFFF_FFFF);
    rd(12'h100, 32'h0000_0000, "unmapped_read");
    rd(12'h010, 32'h0000_0000, "pllctl_reads_zero");
`ifndef N101_HCLKGEN_IRQ_EN
    wr(12'h018, 32'h3);
    rd(12'h018, 32'h0000_0000, "irqen_absent");
`endif

    // 6. Asynchronous reset during the RESET state
    pll_lock = 1'b0;
    wr(12'h010, 32'h1);
    wait_reset_level(1'b1, "midseq_pulse");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pll_RESET", 32'(pll_RESET), 32'h0);
    chk("async_rst_pllbypass", 32'(pllbypass), 32'h1);
    chk("async_rst_pll_M", 32'(pll_M), 32'h32);
    #20 rst_n = 1'b1;
    rd(12'h014, 32'h0000_0000, "post_rst_idle");
    rd(12'h008, 32'h0004_4642, "post_rst_pllcfg");
    rd(12'h024, 32'h0000_0100, "post_rst_div1");

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_data_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
